// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control sequencer
// Steps the latched IR through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath controls combinationally from state, instr and mem_ready.
// Ports:
//   clk, rst_b            clock (rising edge), asynchronous active-low reset
//   en                    run enable, looked at only before a fetch is issued
//   instr, alu_zero       IR contents and ALU zero flag
//   mem_req/mem_we/mem_ready  shared memory port handshake
//   ir_we, pc_we, pc_src, rf_we, reg_dst, wb_sel, alu_src, alu_op  datapath controls
//   state, err, retired   sequencer state, sticky error, retired-instruction count
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             en,
    input  logic [31:0]      instr,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             rf_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_sel,
    output logic             alu_src,
    output logic [2:0]       alu_op,
    output logic [2:0]       state,
    output logic             err,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERROR  = 3'd7
    } state_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // The wait counter never needs to hold MEM_TIMEOUT itself: the cycle that
    // would reach it moves to ERROR instead.
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               err_q, err_d;
    logic               retire;
    logic               fetch_req;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_instr_bits;
    logic       is_rtype_alu, is_jr, is_imm_add, is_ori, is_lw, is_sw;
    logic       is_beq, is_bne, is_j, is_jal, is_legal;
    logic [2:0] rtype_op;

    assign opcode            = instr[31:26];
    assign funct             = instr[5:0];
    assign unused_instr_bits = ^instr[25:6];

    always_comb begin
        is_rtype_alu = 1'b0;
        is_jr        = 1'b0;
        rtype_op     = ALU_ADD;
        if (opcode == 6'h00) begin
            case (funct)
                6'h20:   begin is_rtype_alu = 1'b1; rtype_op = ALU_ADD; end
                6'h22:   begin is_rtype_alu = 1'b1; rtype_op = ALU_SUB; end
                6'h24:   begin is_rtype_alu = 1'b1; rtype_op = ALU_AND; end
                6'h25:   begin is_rtype_alu = 1'b1; rtype_op = ALU_OR;  end
                6'h2A:   begin is_rtype_alu = 1'b1; rtype_op = ALU_SLT; end
                6'h08:   is_jr = 1'b1;
                default: ;
            endcase
        end
    end

    assign is_imm_add = (opcode == 6'h08) || (opcode == 6'h09);
    assign is_ori     = (opcode == 6'h0D);
    assign is_lw      = (opcode == 6'h23);
    assign is_sw      = (opcode == 6'h2B);
    assign is_beq     = (opcode == 6'h04);
    assign is_bne     = (opcode == 6'h05);
    assign is_j       = (opcode == 6'h02);
    assign is_jal     = (opcode == 6'h03);
    assign is_legal   = is_rtype_alu | is_jr | is_imm_add | is_ori | is_lw | is_sw |
                        is_beq | is_bne | is_j | is_jal;

    // A fetch already waiting (wait_q != 0) keeps requesting regardless of en.
    assign fetch_req = en || (wait_q != '0);

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        retire  = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        pc_src  = 2'b00;
        rf_we   = 1'b0;
        reg_dst = 2'b00;
        wb_sel  = 2'b00;
        alu_src = 1'b0;
        alu_op  = ALU_AND;
        // While reset is held every control stays quiet, even if en is high.
        if (rst_b) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = fetch_req;
                    if (fetch_req) begin
                        if (mem_ready) begin
                            ir_we   = 1'b1;
                            pc_we   = 1'b1;
                            state_d = S_DECODE;
                        end else if (wait_q == WAIT_LAST) begin
                            state_d = S_ERROR;
                        end else begin
                            wait_d = wait_q + 1'b1;
                        end
                    end
                end
                S_DECODE: state_d = is_legal ? S_EXEC : S_ERROR;
                S_EXEC: begin
                    state_d = S_WB;
                    if (is_rtype_alu) begin
                        alu_op = rtype_op;
                    end else if (is_imm_add) begin
                        alu_src = 1'b1;
                        alu_op  = ALU_ADD;
                    end else if (is_ori) begin
                        alu_src = 1'b1;
                        alu_op  = ALU_OR;
                    end else if (is_lw || is_sw) begin
                        alu_src = 1'b1;
                        alu_op  = ALU_ADD;
                        state_d = S_MEM;
                    end else begin
                        // Control transfers complete in EXEC.
                        state_d = S_FETCH;
                        retire  = 1'b1;
                        if (is_beq) begin
                            alu_op = ALU_SUB;
                            pc_we  = alu_zero;
                            pc_src = 2'b01;
                        end else if (is_bne) begin
                            alu_op = ALU_SUB;
                            pc_we  = ~alu_zero;
                            pc_src = 2'b01;
                        end else if (is_jr) begin
                            pc_we  = 1'b1;
                            pc_src = 2'b11;
                        end else begin
                            pc_we  = 1'b1;
                            pc_src = 2'b10;
                            if (is_jal) begin
                                rf_we   = 1'b1;
                                reg_dst = 2'b10;
                                wb_sel  = 2'b10;
                            end
                        end
                    end
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = is_sw;
                    alu_src = 1'b1;
                    alu_op  = ALU_ADD;
                    if (mem_ready) begin
                        if (is_sw) begin
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end else if (wait_q == WAIT_LAST) begin
                        state_d = S_ERROR;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                S_WB: begin
                    rf_we   = 1'b1;
                    reg_dst = is_rtype_alu ? 2'b01 : 2'b00;
                    wb_sel  = is_lw ? 2'b01 : 2'b00;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
                S_ERROR: state_d = S_ERROR;
                default: state_d = S_ERROR;
            endcase
        end
    end

    always_comb begin
        retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};
        err_d     = err_q | (state_d == S_ERROR);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            retired_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            err_q     <= err_d;
        end
    end

    assign state   = state_q;
    assign err     = err_q;
    assign retired = retired_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;
    localparam int T  = 16;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          en = 1'b0;
    logic [31:0]   instr = 32'h0;
    logic          alu_zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_we, ir_we, pc_we, rf_we, alu_src, err;
    logic [1:0]    pc_src, reg_dst, wb_sel;
    logic [2:0]    alu_op, state;
    logic [CW-1:0] retired;
    logic [17:0]   ctrl_v;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst_b(rst_b), .en(en), .instr(instr), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .rf_we(rf_we), .reg_dst(reg_dst),
        .wb_sel(wb_sel), .alu_src(alu_src), .alu_op(alu_op), .state(state),
        .err(err), .retired(retired)
    );

    always #5 clk = ~clk;

    assign ctrl_v = {state, mem_req, mem_we, ir_we, pc_we, pc_src, rf_we,
                     reg_dst, wb_sel, alu_src, alu_op};

    typedef enum int {K_R, K_JR, K_IMM, K_ORI, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_BAD} kind_t;

    // One expected clock cycle: inputs to drive, outputs to expect, and which
    // select fields carry a defined value in that cycle.
    typedef struct {
        logic [2:0] st;
        logic       en_v, rdy, z, ret;
        logic       req, mwe, irw, pcw, rfw, asrc;
        logic [1:0] pcs, rdst, wbs;
        logic [2:0] aop;
        logic       m_pcs, m_rdst, m_wbs, m_asrc, m_aop;
    } cyc_t;

    cyc_t          plan[$];
    int            total = 0;
    int            bad = 0;
    logic [CW-1:0] exp_ret = '0;
    logic          exp_err = 1'b0;

    function automatic logic rbit();
        return ($urandom & 1) != 0;
    endfunction

    function automatic kind_t classify(input logic [31:0] ins);
        case (ins[31:26])
            6'h00: begin
                case (ins[5:0])
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: return K_R;
                    6'h08:   return K_JR;
                    default: return K_BAD;
                endcase
            end
            6'h08, 6'h09: return K_IMM;
            6'h0D:   return K_ORI;
            6'h23:   return K_LW;
            6'h2B:   return K_SW;
            6'h04:   return K_BEQ;
            6'h05:   return K_BNE;
            6'h02:   return K_J;
            6'h03:   return K_JAL;
            default: return K_BAD;
        endcase
    endfunction

    function automatic logic [2:0] r_op(input logic [5:0] f);
        case (f)
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2A:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic cyc_t blank(input logic [2:0] st);
        cyc_t c;
        c = '{default: '0};
        c.st   = st;
        c.en_v = rbit();
        c.rdy  = rbit();
        c.z    = rbit();
        return c;
    endfunction

    function automatic void push_error();
        for (int i = 0; i < 3; i++) plan.push_back(blank(3'd7));
    endfunction

    // Request phase: 'waits' cycles without ready, then a ready cycle; a wait
    // of T or more cycles ends in ERROR. Returns 0 if it timed out.
    function automatic bit push_req(input cyc_t b, input int waits, input bit first);
        cyc_t c;
        int   n;
        n = (waits >= T) ? T : waits;
        for (int i = 0; i < n; i++) begin
            c = b;
            c.rdy  = 1'b0;
            c.en_v = (first && i == 0) ? 1'b1 : rbit();
            c.z    = rbit();
            plan.push_back(c);
        end
        if (waits >= T) begin
            push_error();
            return 1'b0;
        end
        c = b;
        c.rdy  = 1'b1;
        c.en_v = (first && n == 0) ? 1'b1 : rbit();
        c.z    = rbit();
        plan.push_back(c);
        return 1'b1;
    endfunction

    function automatic void push_idle(input int idle);
        cyc_t c;
        for (int i = 0; i < idle; i++) begin
            c = blank(3'd0);
            c.en_v = 1'b0;
            plan.push_back(c);
        end
    endfunction

    function automatic void build(input logic [31:0] ins, input logic z,
                                  input int idle, input int fw, input int mw);
        kind_t k;
        cyc_t  c;
        k = classify(ins);
        push_idle(idle);
        c = blank(3'd0);
        c.req   = 1'b1;
        c.m_pcs = 1'b1;
        if (!push_req(c, fw, 1'b1)) return;
        plan[plan.size()-1].irw = 1'b1;
        plan[plan.size()-1].pcw = 1'b1;
        plan.push_back(blank(3'd1));
        if (k == K_BAD) begin
            push_error();
            return;
        end
        c = blank(3'd2);
        c.z = z;
        case (k)
            K_R:   begin c.asrc = 1'b0; c.aop = r_op(ins[5:0]); c.m_asrc = 1'b1; c.m_aop = 1'b1; end
            K_IMM, K_LW, K_SW: begin c.asrc = 1'b1; c.aop = 3'b010; c.m_asrc = 1'b1; c.m_aop = 1'b1; end
            K_ORI: begin c.asrc = 1'b1; c.aop = 3'b001; c.m_asrc = 1'b1; c.m_aop = 1'b1; end
            K_BEQ: begin c.aop = 3'b110; c.m_aop = 1'b1; c.pcw = z;  c.pcs = 2'b01; c.m_pcs = 1'b1; c.ret = 1'b1; end
            K_BNE: begin c.aop = 3'b110; c.m_aop = 1'b1; c.pcw = !z; c.pcs = 2'b01; c.m_pcs = 1'b1; c.ret = 1'b1; end
            K_J:   begin c.pcw = 1'b1; c.pcs = 2'b10; c.m_pcs = 1'b1; c.ret = 1'b1; end
            K_JR:  begin c.pcw = 1'b1; c.pcs = 2'b11; c.m_pcs = 1'b1; c.ret = 1'b1; end
            K_JAL: begin
                c.pcw = 1'b1; c.pcs = 2'b10; c.m_pcs = 1'b1; c.ret = 1'b1;
                c.rfw = 1'b1; c.rdst = 2'b10; c.wbs = 2'b10; c.m_rdst = 1'b1; c.m_wbs = 1'b1;
            end
            default: ;
        endcase
        plan.push_back(c);
        if (c.ret) return;
        if (k == K_LW || k == K_SW) begin
            c = blank(3'd3);
            c.req = 1'b1; c.mwe = (k == K_SW); c.asrc = 1'b1; c.aop = 3'b010;
            c.m_asrc = 1'b1; c.m_aop = 1'b1;
            if (!push_req(c, mw, 1'b0)) return;
            if (k == K_SW) begin
                plan[plan.size()-1].ret = 1'b1;
                return;
            end
        end
        c = blank(3'd4);
        c.rfw = 1'b1;
        c.rdst = (k == K_R) ? 2'b01 : 2'b00;
        c.wbs  = (k == K_LW) ? 2'b01 : 2'b00;
        c.m_rdst = 1'b1; c.m_wbs = 1'b1; c.ret = 1'b1;
        plan.push_back(c);
    endfunction

    // Entered and left at posedge+1; outputs are checked on the falling edge.
    task automatic run_plan(input string name, input int limit);
        logic [17:0] ev, mv;
        for (int i = 0; i < plan.size() && i < limit; i++) begin
            en        = plan[i].en_v;
            mem_ready = plan[i].rdy;
            alu_zero  = plan[i].z;
            @(negedge clk);
            if (plan[i].st == 3'd7) exp_err = 1'b1;
            ev = {plan[i].st, plan[i].req, plan[i].mwe, plan[i].irw, plan[i].pcw, plan[i].pcs,
                  plan[i].rfw, plan[i].rdst, plan[i].wbs, plan[i].asrc, plan[i].aop};
            mv = {3'b111, 4'b1111, {2{plan[i].m_pcs}}, 1'b1, {2{plan[i].m_rdst}},
                  {2{plan[i].m_wbs}}, plan[i].m_asrc, {3{plan[i].m_aop}}};
            total++;
            if ((ctrl_v & mv) !== (ev & mv)) begin
                bad++;
                $display("FAIL %s ctrl cycle %0d: actual=%h required=%h mask=%h", name, i, ctrl_v & mv, ev & mv, mv);
            end
            total++;
            if ({err, retired} !== {exp_err, exp_ret}) begin
                bad++;
                $display("FAIL %s status cycle %0d: actual err=%b retired=%0d required err=%b retired=%0d",
                         name, i, err, retired, exp_err, exp_ret);
            end
            @(posedge clk);
            #1;
            if (plan[i].ret) exp_ret++;
        end
        plan.delete();
    endtask

    task automatic run_instr(input string name, input logic [31:0] ins, input logic z,
                             input int idle, input int fw, input int mw);
        instr = ins;
        build(ins, z, idle, fw, mw);
        run_plan(name, 100000);
    endtask

    task automatic do_reset(input string name);
        en = 1'b1; mem_ready = 1'b1; alu_zero = 1'b1;
        rst_b = 1'b0;
        #1;
        total++;
        if (ctrl_v !== 18'h0 || err !== 1'b0 || retired !== '0) begin
            bad++;
            $display("FAIL %s: actual ctrl=%h err=%b retired=%0d required ctrl=0 err=0 retired=0",
                     name, ctrl_v, err, retired);
        end
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        exp_ret = '0;
        exp_err = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        do_reset("reset");
        push_idle(3);
        run_plan("idle_en_low", 100000);
    endtask

    task automatic test_rtype();
        run_instr("add", 32'h012A4020, 1'b0, 0, 0, 0);
        run_instr("sub_wait", 32'h012A4022, 1'b0, 1, 2, 0);
        run_instr("addi", 32'h21290004, 1'b0, 0, 0, 0);
        run_instr("ori", 32'h3529FFFF, 1'b0, 0, 1, 0);
    endtask

    task automatic test_lw();
        run_instr("lw_delay3", 32'h8D090004, 1'b0, 0, 0, 3);
        run_instr("sw", 32'hAD090004, 1'b0, 0, 0, 0);
        run_instr("sw_delay2", 32'hAD090004, 1'b0, 0, 0, 2);
    endtask

    task automatic test_branch();
        run_instr("beq_taken", 32'h11090002, 1'b1, 0, 0, 0);
        run_instr("beq_not", 32'h11090002, 1'b0, 0, 0, 0);
        run_instr("bne_not", 32'h15090002, 1'b1, 0, 0, 0);
        run_instr("bne_taken", 32'h15090002, 1'b0, 0, 0, 0);
    endtask

    task automatic test_jump();
        run_instr("jal", 32'h0C000010, 1'b0, 0, 0, 0);
        run_instr("jr", 32'h03E00008, 1'b0, 0, 0, 0);
        run_instr("j", 32'h08000010, 1'b0, 0, 0, 0);
    endtask

    task automatic test_illegal();
        run_instr("illegal_op", 32'hFC000000, 1'b0, 0, 0, 0);
        do_reset("reset_after_err");
        run_instr("bad_funct", 32'h012A4021, 1'b0, 0, 0, 0);
        do_reset("reset_after_err2");
        run_instr("add_after_err", 32'h012A4020, 1'b0, 0, 0, 0);
    endtask

    task automatic test_timeout();
        run_instr("fetch_timeout", 32'h012A4020, 1'b0, 0, T, 0);
        do_reset("reset_after_fetch_to");
        run_instr("fetch_edge_ok", 32'h012A4020, 1'b0, 0, T - 1, 0);
        run_instr("mem_edge_ok", 32'h8D090004, 1'b0, 0, 0, T - 1);
        run_instr("mem_timeout", 32'h8D090004, 1'b0, 0, 0, T);
        do_reset("reset_after_mem_to");
    endtask

    task automatic test_reset_mid_mem();
        run_instr("pre_add", 32'h012A4020, 1'b0, 0, 0, 0);
        instr = 32'hAD090004;
        build(instr, 1'b0, 0, 0, 5);
        run_plan("sw_partial", 5);
        do_reset("reset_mid_mem");
        run_instr("add_after_rst", 32'h012A4020, 1'b0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [5:0]  ops[11] = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
        logic [5:0]  fns[6]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08};
        logic [31:0] ins;
        for (int n = 0; n < 60; n++) begin
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(10, 0)];
            if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(5, 0)];
            run_instr("random", ins, rbit(), $urandom_range(1, 0), $urandom_range(3, 0),
                      $urandom_range(3, 0));
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw();
        test_branch();
        test_jump();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle control sequencer for the MIPS datapath.
- Decodes the latched instruction register (IR) and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives PC, IR, register-file, ALU and memory control, with a req/ready handshake to the shared instruction/data memory port.
- Counts retired instructions; flags illegal opcodes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 16, max cycles mem_req may wait for mem_ready before ERROR (>=1).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  asynchronous reset, active-low.
- en  in  1  run enable; sampled only in FETCH before a request is issued.
- instr  in  32  IR contents, valid from the cycle after ir_we.
- alu_zero  in  1  ALU zero flag, valid in EXEC.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write (store).
- ir_we  out  1  latch fetched word into IR.
- pc_we  out  1  PC update.
- pc_src  out  2  00 PC+4, 01 branch target, 10 jump target {PC+4[31:28],imm26,00}, 11 rs (JR).
- rf_we  out  1  register-file write.
- reg_dst  out  2  00 rt, 01 rd, 10 r31.
- wb_sel  out  2  00 ALU, 01 memory data, 10 PC+4 (link).
- alu_src  out  1  0 rt, 1 sign-extended immediate.
- alu_op  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- state  out  3  0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 7 ERROR.
- err  out  1  sticky error.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, rst_b low): state=FETCH, wait counter=0, retired=0, err=0. All strobes (mem_req, mem_we, ir_we, pc_we, rf_we) are 0; mux selects are 0. Reset asserted mid-instruction abandons it with no write.
- Strobes are Moore/Mealy combinational from state, instr and mem_ready. All registers update on the rising edge of clk.
- FETCH:
  - If en=0: no request; hold FETCH.
  - If en=1: mem_req=1, mem_we=0.
  - On mem_ready=1 in the same cycle: ir_we=1, pc_we=1, pc_src=00, go to DECODE.
  - Once mem_req rises, en is ignored until the fetch completes.
- DECODE: one cycle, no strobes. Supported instructions:
  - Opcode 0x00 with funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT, 0x08 JR.
  - Opcodes 0x08 ADDI, 0x09 ADDIU, 0x0D ORI, 0x23 LW, 0x2B SW, 0x04 BEQ, 0x05 BNE, 0x02 J, 0x03 JAL.
  - Anything else: go to ERROR. Otherwise go to EXEC.
- EXEC: drives alu_op/alu_src for the whole cycle.
  - R-type ALU ops: alu_src=0, op per funct; go to WB.
  - ADDI/ADDIU: ADD, alu_src=1; go to WB.
  - ORI: OR, alu_src=1; go to WB.
  - LW/SW: ADD, alu_src=1 (address); go to MEM.
  - BEQ: SUB; pc_we=alu_zero, pc_src=01; retire; go to FETCH.
  - BNE: SUB; pc_we=~alu_zero, pc_src=01; retire; go to FETCH.
  - J: pc_we=1, pc_src=10; retire; go to FETCH.
  - JAL: same as J, plus rf_we=1, reg_dst=10, wb_sel=10; retire; go to FETCH.
  - JR: pc_we=1, pc_src=11; retire; go to FETCH.
- MEM: mem_req=1, mem_we=1 for SW.
  - On mem_ready: SW retires and goes to FETCH; LW goes to WB.
  - Hold otherwise, with ALU controls held.
- WB: rf_we=1 for one cycle; retire; go to FETCH.
  - R-type: reg_dst=01, wb_sel=00.
  - Immediate ops: reg_dst=00, wb_sel=00.
  - LW: reg_dst=00, wb_sel=01.
- Latencies with mem_ready on the first request cycle:
  - R/imm: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch/jump: 3 cycles.
- Timeout: the wait counter increments each FETCH/MEM cycle with mem_req=1 and mem_ready=0, and clears on mem_ready or a state change. If the counter reaches MEM_TIMEOUT, go to ERROR next edge. mem_ready arriving on that same cycle wins, i.e. no error.
- ERROR: err=1, all strobes 0, mem_req=0; stays there until reset.
- retired: +1 on the final cycle of each instruction; wraps modulo 2^CNT_W; never increments in ERROR.
- BEQ/BNE outcome uses alu_zero sampled in EXEC only.

Test Plan:
- Reset then en=1, fetch ADD (0x012A4020), mem_ready immediate -> states 0,1,2,4,0. alu_op=010 in EXEC. WB: rf_we=1, reg_dst=01. retired=1.
- LW (0x8D090004) with mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles. WB: wb_sel=01, reg_dst=00. Total 8 cycles.
- BEQ (0x11090002): alu_zero=1 -> pc_we=1, pc_src=01 in EXEC. Repeat with alu_zero=0 -> pc_we=0. BNE gives inverse results. Each takes 3 cycles.
- JAL (0x0C000010) -> EXEC: pc_we=1, pc_src=10, rf_we=1, reg_dst=10, wb_sel=10. JR (0x03E00008) -> pc_src=11.
- Opcode 0x3F -> ERROR after DECODE: err=1, no strobes, retired unchanged. Only rst_b low clears it.
- MEM_TIMEOUT=16 with mem_ready never asserted in FETCH -> ERROR after 16 waiting cycles. mem_ready on cycle 16 -> no error. rst_b low mid-MEM -> immediate FETCH with all strobes 0.
